spw_buffer_ctrl: RTL

Slot allocator and write arbiter for the shared pointer-addressed crossbar buffer (DEPTH = 2^PTR_WIDTH slots).
- Write side: round-robins among NUM_REQ requesters, allocates the lowest-index free slot, and drives the buffer write port.
- Read/free side: drives the buffer read port and releases the slot.
- Tracks occupancy with a free bitmap and a free counter.

---
 rtl/spw_buffer_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/spw_buffer_ctrl.sv
// Slot allocator and round-robin write arbiter for a shared pointer-addressed buffer.
// Optional duplicate-free detection is enabled by defining SPW_BUFFER_CTRL_ERR_CHK_EN.
module spw_buffer_ctrl #(
  parameter int PTR_WIDTH  = 3,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_grant_o,
  output logic [PTR_WIDTH-1:0]          grant_ptr_o,
  output logic                          buf_wr_en_o,
  output logic [PTR_WIDTH-1:0]          buf_write_ptr_o,
  output logic [DATA_WIDTH-1:0]         buf_write_data_o,
  input  logic                          free_valid_i,
  input  logic [PTR_WIDTH-1:0]          free_ptr_i,
  output logic                          buf_rd_en_o,
  output logic [PTR_WIDTH-1:0]          buf_read_ptr_o,
  output logic [PTR_WIDTH:0]            free_cnt_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic                          err_o
);

  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam int RR_W  = $clog2(NUM_REQ);

  logic [DEPTH-1:0]     free_map_q, free_map_d;
  logic [RR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_WIDTH:0]   free_cnt_q, free_cnt_d;
  logic                 full_q, full_d, empty_q, empty_d, err_q, err_d;

  logic                 alloc_s;
  logic [RR_W-1:0]      winner_s;
  logic [PTR_WIDTH-1:0] slot_s;
  logic                 was_free_s, free_acc_s;
  logic [DEPTH-1:0]     set_mask_s;

  function automatic logic [PTR_WIDTH-1:0] lowest_set(input logic [DEPTH-1:0] map);
    logic [PTR_WIDTH-1:0] idx;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (map[i]) idx = PTR_WIDTH'(i);
      else        idx = idx;
    end
    return idx;
  endfunction

  // Rotate so the priority holder sits at bit 0, take the first set bit, rotate back.
  function automatic logic [RR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [RR_W-1:0]    start);
    logic [NUM_REQ-1:0] rot;
    logic [RR_W-1:0]    off;
    logic [RR_W:0]      sum;
    rot = NUM_REQ'({req, req} >> start);
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = RR_W'(i);
      else        off = off;
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= (RR_W+1)'(NUM_REQ)) sum = sum - (RR_W+1)'(NUM_REQ);
    else                           sum = sum;
    return sum[RR_W-1:0];
  endfunction

  // Write-side arbitration and buffer write port.
  always_comb begin
    alloc_s          = (|req_valid_i) & (|free_map_q) & ~rst_i;
    winner_s         = rr_pick(req_valid_i, rr_ptr_q);
    slot_s           = lowest_set(free_map_q);
    req_grant_o      = '0;
    grant_ptr_o      = '0;
    buf_wr_en_o      = 1'b0;
    buf_write_ptr_o  = '0;
    buf_write_data_o = '0;
    if (alloc_s) begin
      req_grant_o     = NUM_REQ'(1) << winner_s;
      grant_ptr_o     = slot_s;
      buf_wr_en_o     = 1'b1;
      buf_write_ptr_o = slot_s;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (winner_s == RR_W'(r)) buf_write_data_o = req_data_i[r*DATA_WIDTH +: DATA_WIDTH];
        else                      buf_write_data_o = buf_write_data_o;
      end
    end else begin
      req_grant_o = '0;
    end
  end

  assign buf_rd_en_o    = free_valid_i;
  assign buf_read_ptr_o = free_ptr_i;

  // Next-state: bitmap, counter, round-robin pointer and status flags.
  always_comb begin
    was_free_s = free_map_q[free_ptr_i];
    free_acc_s = free_valid_i & ~was_free_s;
`ifdef SPW_BUFFER_CTRL_ERR_CHK_EN
    set_mask_s = free_acc_s ? (DEPTH'(1) << free_ptr_i) : '0;
    err_d      = err_q | (free_valid_i & was_free_s);
`else
    set_mask_s = free_valid_i ? (DEPTH'(1) << free_ptr_i) : '0;
    err_d      = 1'b0;
`endif
    // Clear after set so an illegal same-slot alloc+free stays consistent with the count.
    free_map_d = free_map_q | set_mask_s;
    if (alloc_s) begin
      free_map_d = free_map_d & ~(DEPTH'(1) << slot_s);
      rr_ptr_d   = (winner_s == RR_W'(NUM_REQ - 1)) ? '0 : winner_s + RR_W'(1);
    end else begin
      rr_ptr_d   = rr_ptr_q;
    end
    free_cnt_d = free_cnt_q - (PTR_WIDTH+1)'(alloc_s) + (PTR_WIDTH+1)'(free_acc_s);
    full_d     = (free_cnt_d == (PTR_WIDTH+1)'(0));
    empty_d    = (free_cnt_d == (PTR_WIDTH+1)'(DEPTH));
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      free_map_q <= '1;
      rr_ptr_q   <= '0;
      free_cnt_q <= (PTR_WIDTH+1)'(DEPTH);
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      free_map_q <= free_map_d;
      rr_ptr_q   <= rr_ptr_d;
      free_cnt_q <= free_cnt_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      err_q      <= err_d;
    end
  end

  assign free_cnt_o = free_cnt_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign err_o      = err_q;

endmodule
